// File: rtl/uart_fifo_pkg.sv
// Shared defaults and helpers for the UART TX/RX synchronous FIFOs.
package uart_fifo_pkg;

  localparam int DW_DEF     = 8;
  localparam int AW_DEF     = 4;
  localparam int AE_LVL_DEF = 2;
  localparam int AF_LVL_DEF = (1 << AW_DEF) - 2;

  // Ceiling log2, e.g. for sizing an address from a requested depth.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one registered read port, no reset.
module uart_fifo_ram #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1 << AW) - 1];
  logic [DW-1:0] rdata_q;

  // Write port plus read-first read port; the read register only loads on an accepted read.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with level flags, sticky overflow/underflow and synchronous flush.
module uart_sync_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int AE_LVL = AE_LVL_DEF,
  parameter int AF_LVL = (1 << AW) - 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [DW-1:0] di,
  input  logic          re,
  output logic [DW-1:0] do_o,
  output logic          empty_flag,
  output logic          aempty_flag,
  output logic          afull_flag,
  output logic          full_flag,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          udf,
  input  logic          err_clr
);

  localparam logic [AW:0] DEPTH_C  = (AW + 1)'(1 << AW);
  localparam logic [AW:0] AE_LVL_C = (AW + 1)'(AE_LVL);
  localparam logic [AW:0] AF_LVL_C = (AW + 1)'(AF_LVL);
  localparam logic [AW:0] ONE_C    = (AW + 1)'(1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          rd_vld_q, rd_vld_d;
  logic          wr_acc, rd_acc;
  logic [DW-1:0] ram_rdata;

  // Level flags come straight from the registered count.
  assign empty_flag  = (count_q == '0);
  assign aempty_flag = (count_q <= AE_LVL_C);
  assign afull_flag  = (count_q >= AF_LVL_C);
  assign full_flag   = (count_q == DEPTH_C);
  assign count       = count_q;
  assign ovf         = ovf_q;
  assign udf         = udf_q;

  // Until the first accepted read after reset the RAM read register holds stale data, so mask it.
  assign do_o = rd_vld_q ? ram_rdata : '0;

  // Accept/reject decisions and next-state for pointers, count and sticky error flags.
  always_comb begin
    // A read always succeeds when not empty, so a full FIFO can take a write alongside it.
    rd_acc   = re & ~empty_flag & ~clr;
    wr_acc   = we & (~full_flag | re) & ~clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    rd_vld_d = rd_vld_q | rd_acc;

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
      if (we & full_flag & ~re) begin
        ovf_d = 1'b1;
      end
      if (re & empty_flag) begin
        udf_d = 1'b1;
      end
    end

    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  uart_fifo_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk    (clk),
    .we_i   (wr_acc),
    .waddr_i(wr_ptr_q),
    .wdata_i(di),
    .re_i   (rd_acc),
    .raddr_i(rd_ptr_q),
    .rdata_o(ram_rdata)
  );

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Directed self-checking bench for uart_sync_fifo (DW=8, AW=4).
module tb_uart_sync_fifo;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          we;
  logic [DW-1:0] di;
  logic          re;
  logic [DW-1:0] do_o;
  logic          empty_flag;
  logic          aempty_flag;
  logic          afull_flag;
  logic          full_flag;
  logic [AW:0]   count;
  logic          ovf;
  logic          udf;
  logic          err_clr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_sync_fifo #(
    .DW    (DW),
    .AW    (AW),
    .AE_LVL(2),
    .AF_LVL(14)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .we         (we),
    .di         (di),
    .re         (re),
    .do_o       (do_o),
    .empty_flag (empty_flag),
    .aempty_flag(aempty_flag),
    .afull_flag (afull_flag),
    .full_flag  (full_flag),
    .count      (count),
    .ovf        (ovf),
    .udf        (udf),
    .err_clr    (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of traffic; prints one line per transaction.
  task automatic xfer(input logic w, input logic r, input logic [DW-1:0] d);
    we = w;
    re = r;
    di = d;
    tick();
    we = 1'b0;
    re = 1'b0;
    $display("[TB] we=%0b re=%0b di=0x%02h clr=%0b err_clr=%0b -> do=0x%02h count=%0d ovf=%0b udf=%0b",
             w, r, d, clr, err_clr, do_o, count, ovf, udf);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"},  32'(count),       32'd0);
    check({tag, "_do"},     32'(do_o),        32'h00);
    check({tag, "_empty"},  32'(empty_flag),  32'd1);
    check({tag, "_aempty"}, 32'(aempty_flag), 32'd1);
    check({tag, "_afull"},  32'(afull_flag),  32'd0);
    check({tag, "_full"},   32'(full_flag),   32'd0);
    check({tag, "_ovf"},    32'(ovf),         32'd0);
    check({tag, "_udf"},    32'(udf),         32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    di      = '0;
    err_clr = 1'b0;

    // Reset state
    tick();
    tick();
    check_reset_state("rst");
    #3 rst_n = 1'b1;
    tick();

    // Fill 0x00..0x0F: afull from 14, full at 16
    for (int i = 0; i < 16; i++) begin
      xfer(1'b1, 1'b0, 8'(i));
      check("fill_count",  32'(count),       32'(i + 1));
      check("fill_afull",  32'(afull_flag),  32'(i + 1 >= 14));
      check("fill_full",   32'(full_flag),   32'(i + 1 == 16));
      check("fill_aempty", 32'(aempty_flag), 32'(i + 1 <= 2));
      check("fill_empty",  32'(empty_flag),  32'd0);
    end

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, 1'b1, 8'h00);
      check("drain_do",    32'(do_o),  32'(i));
      check("drain_count", 32'(count), 32'(15 - i));
    end
    check("drain_empty", 32'(empty_flag), 32'd1);
    xfer(1'b0, 1'b0, 8'h00);
    check("do_hold", 32'(do_o), 32'h0F);

    // Underflow: read while empty leaves do alone, sets udf
    xfer(1'b0, 1'b1, 8'h00);
    check("udf_set",   32'(udf),   32'd1);
    check("udf_do",    32'(do_o),  32'h0F);
    check("udf_count", 32'(count), 32'd0);
    err_clr = 1'b1;
    xfer(1'b0, 1'b0, 8'h00);
    err_clr = 1'b0;
    check("udf_clr", 32'(udf), 32'd0);

    // Overflow: 16 writes then 0xAA
    for (int i = 0; i < 16; i++) begin
      xfer(1'b1, 1'b0, 8'(8'h10 + i));
    end
    xfer(1'b1, 1'b0, 8'hAA);
    check("ovf_set",   32'(ovf),   32'd1);
    check("ovf_count", 32'(count), 32'd16);
    err_clr = 1'b1;
    xfer(1'b0, 1'b0, 8'h00);
    err_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 32'd0);
    // err_clr wins over a simultaneous overflow event
    err_clr = 1'b1;
    xfer(1'b1, 1'b0, 8'hAA);
    err_clr = 1'b0;
    check("ovf_prio", 32'(ovf), 32'd0);
    check("ovf_prio_count", 32'(count), 32'd16);

    // Simultaneous write/read while full: both accepted, old head read out
    xfer(1'b1, 1'b1, 8'h55);
    check("full_wr_count", 32'(count), 32'd16);
    check("full_wr_ovf",   32'(ovf),   32'd0);
    check("full_wr_do",    32'(do_o),  32'h10);
    for (int i = 0; i < 15; i++) begin
      xfer(1'b0, 1'b1, 8'h00);
      check("ovf_drain_do", 32'(do_o), 32'(8'h11 + i));
    end
    xfer(1'b0, 1'b1, 8'h00);
    check("ovf_drain_last", 32'(do_o),       32'h55);
    check("ovf_drain_empty", 32'(empty_flag), 32'd1);

    // Simultaneous write/read while empty: only write taken, udf set
    xfer(1'b1, 1'b1, 8'h66);
    check("empty_wr_count", 32'(count), 32'd1);
    check("empty_wr_udf",   32'(udf),   32'd1);
    check("empty_wr_do",    32'(do_o),  32'h55);
    err_clr = 1'b1;
    xfer(1'b0, 1'b1, 8'h00);
    err_clr = 1'b0;
    check("empty_wr_rd", 32'(do_o), 32'h66);
    check("empty_wr_udfclr", 32'(udf), 32'd0);

    // Wrap-around: keep two entries in flight over 40 write+read pairs
    xfer(1'b1, 1'b0, 8'h80);
    xfer(1'b1, 1'b0, 8'h81);
    for (int i = 0; i < 40; i++) begin
      xfer(1'b1, 1'b1, 8'(8'h82 + i));
      check("wrap_do",     32'(do_o),        32'(8'h80 + i));
      check("wrap_count",  32'(count),       32'd2);
      check("wrap_aempty", 32'(aempty_flag), 32'd1);
    end
    xfer(1'b0, 1'b1, 8'h00);
    check("wrap_tail0", 32'(do_o), 32'hA8);
    xfer(1'b0, 1'b1, 8'h00);
    check("wrap_tail1", 32'(do_o), 32'hA9);

    // Flush at count 5 with traffic asserted: traffic ignored, do kept
    for (int i = 0; i < 5; i++) begin
      xfer(1'b1, 1'b0, 8'(8'h30 + i));
    end
    check("clr_pre_count", 32'(count), 32'd5);
    clr = 1'b1;
    xfer(1'b1, 1'b1, 8'hEE);
    clr = 1'b0;
    check("clr_count", 32'(count),      32'd0);
    check("clr_empty", 32'(empty_flag), 32'd1);
    check("clr_do",    32'(do_o),       32'hA9);
    check("clr_udf",   32'(udf),        32'd0);
    xfer(1'b1, 1'b0, 8'h77);
    xfer(1'b0, 1'b1, 8'h00);
    check("clr_fresh_do", 32'(do_o), 32'h77);

    // Asynchronous reset mid-cycle at count 7 with udf set
    xfer(1'b0, 1'b1, 8'h00);
    check("pre_rst_udf", 32'(udf), 32'd1);
    for (int i = 0; i < 7; i++) begin
      xfer(1'b1, 1'b0, 8'(8'h40 + i));
    end
    check("pre_rst_count", 32'(count), 32'd7);
    #3 rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    #2 rst_n = 1'b1;
    tick();
    xfer(1'b1, 1'b0, 8'hC3);
    check("post_rst_count", 32'(count), 32'd1);
    xfer(1'b0, 1'b1, 8'h00);
    check("post_rst_do", 32'(do_o), 32'hC3);
    check("post_rst_empty", 32'(empty_flag), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
